// File: rtl/nn_defs.sv
// Shared definitions for the network host side: number format, status codes,
// sequencer state encoding and the packed/unpacked array conversion macros.
`ifndef NN_DEFS_SV
`define NN_DEFS_SV

`define PACK_ARRAY(W, N, DST, SRC, LBL) \
    for (genvar gi = 0; gi < (N); gi++) begin : LBL \
        assign DST[(W)*gi +: (W)] = SRC[gi]; \
    end

`define UNPACK_ARRAY(W, N, DST, SRC, LBL) \
    for (genvar gi = 0; gi < (N); gi++) begin : LBL \
        assign DST[gi] = SRC[(W)*gi +: (W)]; \
    end

package nn_defs;

    localparam int NUM_WIDTH = 32;
    localparam int FRAC_BITS = 24;

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_FP_TO = 2'd1,
        ST_BP_TO = 2'd2
    } status_e;

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        FWD_WAIT,
        ARGMAX,
        GRAD,
        BWD,
        BWD_WAIT,
        RESULT
    } seq_state_e;

endpackage

`endif

// File: rtl/sat_sub_shift.sv
// Output-layer gradient element: (minuend - subtrahend) >>> SHIFT computed one
// bit wider than the operands, then saturated back to WIDTH signed bits.
module sat_sub_shift #(
    parameter int WIDTH = nn_defs::NUM_WIDTH,
    parameter int SHIFT = 4
) (
    input  logic signed [WIDTH-1:0] minuend,
    input  logic signed [WIDTH-1:0] subtrahend,
    output logic signed [WIDTH-1:0] result
);
    import nn_defs::*;

    logic signed [WIDTH:0] diff;
    logic signed [WIDTH:0] shifted;

    assign diff    = {minuend[WIDTH-1], minuend} - {subtrahend[WIDTH-1], subtrahend};
    assign shifted = diff >>> SHIFT;

    // Disagreeing top two bits mean the value does not fit in WIDTH bits.
    always_comb begin
        if (shifted[WIDTH] != shifted[WIDTH-1]) begin
            result = shifted[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            result = shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/train_sequencer.sv
// Host-side initiator for the network core: accepts a sample, runs the forward
// pass, scans for the argmax, optionally runs backprop, and returns the result.
module train_sequencer #(
    parameter int NUM_WIDTH   = nn_defs::NUM_WIDTH,
    parameter int INPUT_SIZE  = 16,
    parameter int OUTPUT_SIZE = 8,
    parameter int INDEX_WIDTH = 5,
    parameter int LR_SHIFT    = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic                              s_train,
    input  logic [INPUT_SIZE*NUM_WIDTH-1:0]   s_x_pk,
    input  logic [OUTPUT_SIZE*NUM_WIDTH-1:0]  s_t_pk,
    output logic                              fp,
    input  logic                              fp_out,
    output logic [INPUT_SIZE*NUM_WIDTH-1:0]   a0_pk,
    input  logic [OUTPUT_SIZE*NUM_WIDTH-1:0]  a3_pk,
    output logic                              bp,
    input  logic                              bp_out,
    output logic [OUTPUT_SIZE*NUM_WIDTH-1:0]  g3_pk,
    output logic                              r_valid,
    input  logic                              r_ready,
    output logic [INDEX_WIDTH-1:0]            r_class,
    output logic [1:0]                        r_status
);
    import nn_defs::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int IDX_W = $clog2(OUTPUT_SIZE);

    seq_state_e                        state;
    seq_state_e                        state_next;
    status_e                           status_q;
    logic [CNT_W-1:0]                  wait_cnt;
    logic [INDEX_WIDTH-1:0]            scan_idx;
    logic                              train_q;
    logic [OUTPUT_SIZE*NUM_WIDTH-1:0]  t_q;
    logic [OUTPUT_SIZE*NUM_WIDTH-1:0]  a3_q;
    logic [OUTPUT_SIZE*NUM_WIDTH-1:0]  g3_next;
    logic signed [NUM_WIDTH-1:0]       best_val;
    logic signed [NUM_WIDTH-1:0]       t_arr  [OUTPUT_SIZE];
    logic signed [NUM_WIDTH-1:0]       a3_arr [OUTPUT_SIZE];
    logic signed [NUM_WIDTH-1:0]       g3_arr [OUTPUT_SIZE];
    logic                              wait_hit;
    logic                              scan_last;

    assign wait_hit  = (wait_cnt == CNT_W'(TIMEOUT));
    assign scan_last = (scan_idx == INDEX_WIDTH'(OUTPUT_SIZE - 1));
    assign r_status  = status_q;

    `UNPACK_ARRAY(NUM_WIDTH, OUTPUT_SIZE, t_arr, t_q, g_unpack_t)
    `UNPACK_ARRAY(NUM_WIDTH, OUTPUT_SIZE, a3_arr, a3_q, g_unpack_a3)

    for (genvar k = 0; k < OUTPUT_SIZE; k++) begin : g_grad
        sat_sub_shift #(
            .WIDTH (NUM_WIDTH),
            .SHIFT (LR_SHIFT)
        ) u_sat_sub_shift (
            .minuend    (t_arr[k]),
            .subtrahend (a3_arr[k]),
            .result     (g3_arr[k])
        );
    end

    `PACK_ARRAY(NUM_WIDTH, OUTPUT_SIZE, g3_next, g3_arr, g_pack_g3)

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (s_valid) state_next = FWD;
            FWD:      state_next = FWD_WAIT;
            FWD_WAIT: begin
                if (fp_out) begin
                    state_next = ARGMAX;
                end else if (wait_hit) begin
                    state_next = RESULT;
                end
            end
            ARGMAX:   if (scan_last) state_next = train_q ? GRAD : RESULT;
            GRAD:     state_next = BWD;
            BWD:      state_next = BWD_WAIT;
            BWD_WAIT: if (bp_out || wait_hit) state_next = RESULT;
            RESULT:   if (r_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Start pulses are gated by reset so they drop in the cycle reset is seen.
    always_comb begin
        s_ready = (state == IDLE);
        fp      = rst_n && (state == FWD);
        bp      = rst_n && (state == BWD);
        r_valid = (state == RESULT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a0_pk    <= '0;
            g3_pk    <= '0;
            t_q      <= '0;
            a3_q     <= '0;
            train_q  <= 1'b0;
            wait_cnt <= '0;
            scan_idx <= '0;
            best_val <= '0;
            r_class  <= '0;
            status_q <= ST_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        a0_pk    <= s_x_pk;
                        t_q      <= s_t_pk;
                        train_q  <= s_train;
                        r_class  <= '0;
                        status_q <= ST_OK;
                    end
                end
                FWD: wait_cnt <= '0;
                FWD_WAIT: begin
                    if (fp_out) begin
                        a3_q     <= a3_pk;
                        scan_idx <= '0;
                    end else if (wait_hit) begin
                        status_q <= ST_FP_TO;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                // Strict greater-than keeps the lowest index on ties.
                ARGMAX: begin
                    if (scan_idx == '0 || a3_arr[scan_idx[IDX_W-1:0]] > best_val) begin
                        best_val <= a3_arr[scan_idx[IDX_W-1:0]];
                        r_class  <= scan_idx;
                    end
                    scan_idx <= scan_idx + 1'b1;
                end
                GRAD: g3_pk <= g3_next;
                BWD:  wait_cnt <= '0;
                BWD_WAIT: begin
                    if (bp_out) begin
                        status_q <= ST_OK;
                    end else if (wait_hit) begin
                        status_q <= ST_BP_TO;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_train_sequencer.sv
// Directed bench for train_sequencer: a vector table driven through a stub
// network, plus hand-written backpressure, stray-pulse and mid-run reset cases.
module tb_train_sequencer;
    import nn_defs::*;

    localparam int NW  = NUM_WIDTH;
    localparam int IN  = 16;
    localparam int OUT = 8;
    localparam int IW  = 5;
    localparam int AW  = OUT * NW;
    localparam int XW  = IN * NW;
    localparam logic [31:0] U = 32'(1) << FRAC_BITS;

    typedef struct {
        logic           train;
        int             fpd;
        int             bpd;
        logic [AW-1:0]  a3;
        logic [AW-1:0]  t;
        logic [AW-1:0]  g3;
        logic [AW-1:0]  g3_sat;
        logic           chk_cls;
        logic [IW-1:0]  cls;
        logic [1:0]     st;
        int             fpn;
        int             bpn;
        int             lat;
        logic           chk_g3;
    } vec_t;

    logic           clk;
    logic           rst_n;
    logic           s_valid;
    logic           s_ready;
    logic           s_train;
    logic [XW-1:0]  s_x_pk;
    logic [AW-1:0]  s_t_pk;
    logic           fp;
    logic           fp_out;
    logic [XW-1:0]  a0_pk;
    logic [AW-1:0]  a3_pk;
    logic           bp;
    logic           bp_out;
    logic [AW-1:0]  g3_pk;
    logic           r_valid;
    logic           r_ready;
    logic [IW-1:0]  r_class;
    logic [1:0]     r_status;

    logic           z_s_ready;
    logic           z_fp;
    logic [XW-1:0]  z_a0_pk;
    logic           z_bp;
    logic [AW-1:0]  z_g3_pk;
    logic           z_r_valid;
    logic [IW-1:0]  z_r_class;
    logic [1:0]     z_r_status;

    int   checks = 0;
    int   failures = 0;
    int   fp_delay = 0;
    int   bp_delay = 0;
    int   fp_timer = 0;
    int   bp_timer = 0;
    int   fp_count = 0;
    int   bp_count = 0;
    logic fp_pulse = 1'b0;
    logic bp_pulse = 1'b0;
    logic stray_fp = 1'b0;
    vec_t vecs [8];

    train_sequencer #(.LR_SHIFT(4)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_train(s_train), .s_x_pk(s_x_pk), .s_t_pk(s_t_pk), .fp(fp),
        .fp_out(fp_out), .a0_pk(a0_pk), .a3_pk(a3_pk), .bp(bp), .bp_out(bp_out),
        .g3_pk(g3_pk), .r_valid(r_valid), .r_ready(r_ready), .r_class(r_class),
        .r_status(r_status)
    );

    // Unshifted twin runs in lockstep so saturation at the operand limits is visible.
    train_sequencer #(.LR_SHIFT(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(z_s_ready),
        .s_train(s_train), .s_x_pk(s_x_pk), .s_t_pk(s_t_pk), .fp(z_fp),
        .fp_out(fp_out), .a0_pk(z_a0_pk), .a3_pk(a3_pk), .bp(z_bp), .bp_out(bp_out),
        .g3_pk(z_g3_pk), .r_valid(z_r_valid), .r_ready(r_ready), .r_class(z_r_class),
        .r_status(z_r_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fp_out = fp_pulse | stray_fp;
    assign bp_out = bp_pulse;

    // Stub network: a delay of 0 means the done pulse never comes.
    always @(negedge clk) begin
        fp_count <= fp_count + (fp ? 1 : 0);
        bp_count <= bp_count + (bp ? 1 : 0);
        if (fp) begin
            fp_timer <= fp_delay;
            fp_pulse <= 1'b0;
        end else if (fp_timer > 0) begin
            fp_timer <= fp_timer - 1;
            fp_pulse <= (fp_timer == 1);
        end else begin
            fp_pulse <= 1'b0;
        end
        if (bp) begin
            bp_timer <= bp_delay;
            bp_pulse <= 1'b0;
        end else if (bp_timer > 0) begin
            bp_timer <= bp_timer - 1;
            bp_pulse <= (bp_timer == 1);
        end else begin
            bp_pulse <= 1'b0;
        end
    end

    function automatic logic [AW-1:0] pk(input logic [31:0] e0, input logic [31:0] e1,
                                         input logic [31:0] e2, input logic [31:0] e3,
                                         input logic [31:0] e4, input logic [31:0] e5,
                                         input logic [31:0] e6, input logic [31:0] e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    function automatic vec_t mk(input logic train, input int fpd, input int bpd,
                                input logic [AW-1:0] a3, input logic [AW-1:0] t,
                                input logic [AW-1:0] g3, input logic [AW-1:0] g3_sat,
                                input logic chk_cls, input logic [IW-1:0] cls,
                                input logic [1:0] st, input int fpn, input int bpn,
                                input int lat, input logic chk_g3);
        vec_t v;
        v.train = train;  v.fpd = fpd;  v.bpd = bpd;
        v.a3 = a3;  v.t = t;  v.g3 = g3;  v.g3_sat = g3_sat;
        v.chk_cls = chk_cls;  v.cls = cls;  v.st = st;
        v.fpn = fpn;  v.bpn = bpn;  v.lat = lat;  v.chk_g3 = chk_g3;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic startSample(input vec_t v, input int tag);
        logic [XW-1:0] x;
        x = {IN{32'(tag) ^ 32'hA5A5_0000}};
        s_train  = v.train;
        s_t_pk   = v.t;
        a3_pk    = v.a3;
        s_x_pk   = x;
        fp_delay = v.fpd;
        bp_delay = v.bpd;
        for (int i = 0; i < 20 && !s_ready; i++) begin
            @(posedge clk); #1;
        end
        checkOutput($sformatf("t%0d_s_ready_before_accept", tag), 512'(s_ready), 512'(1));
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        checkOutput($sformatf("t%0d_fp_after_accept", tag), 512'(fp), 512'(1));
        checkOutput($sformatf("t%0d_a0_latched", tag), 512'(a0_pk), 512'(x));
    endtask

    task automatic applyStimulus(input vec_t v, input int tag, input logic ready);
        int fp0;
        int bp0;
        int lat;
        fp0 = fp_count;
        bp0 = bp_count;
        r_ready = ready;
        startSample(v, tag);
        lat = 0;
        while (!r_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput($sformatf("t%0d_latency", tag), 512'(lat), 512'(v.lat));
        if (v.chk_cls) checkOutput($sformatf("t%0d_class", tag), 512'(r_class), 512'(v.cls));
        checkOutput($sformatf("t%0d_status", tag), 512'(r_status), 512'(v.st));
        checkOutput($sformatf("t%0d_fp_pulses", tag), 512'(fp_count - fp0), 512'(v.fpn));
        checkOutput($sformatf("t%0d_bp_pulses", tag), 512'(bp_count - bp0), 512'(v.bpn));
        if (v.chk_g3) begin
            checkOutput($sformatf("t%0d_g3", tag), 512'(g3_pk), 512'(v.g3));
            checkOutput($sformatf("t%0d_g3_unshifted", tag), 512'(z_g3_pk), 512'(v.g3_sat));
        end
    endtask

    initial begin
        vecs[0] = mk(1'b0, 3, 0, pk(0, U, 5*U, 2*U, -3*U, 4*U, U, 0), '0,
                     '0, '0, 1'b1, 5'd2, 2'd0, 1, 0, 12, 1'b1);
        vecs[1] = mk(1'b1, 3, 2,
                     pk(32'h0010_0000, 32'h0020_0000, 32'h0030_0000, 0, 32'h0080_0000, 0, 0, 0),
                     pk(32'h0010_0000, 32'h0020_0000, 32'h0030_0000, 0, 32'h0100_0000, 0, 0, 0),
                     pk(0, 0, 0, 0, 32'h0008_0000, 0, 0, 0),
                     pk(0, 0, 0, 0, 32'h0080_0000, 0, 0, 0),
                     1'b1, 5'd4, 2'd0, 1, 1, 16, 1'b1);
        vecs[2] = mk(1'b1, 3, 2, {OUT{32'h8000_0000}}, {OUT{32'h7FFF_FFFF}},
                     {OUT{32'h0FFF_FFFF}}, {OUT{32'h7FFF_FFFF}},
                     1'b1, 5'd0, 2'd0, 1, 1, 16, 1'b1);
        vecs[3] = mk(1'b1, 3, 2, {OUT{32'h7FFF_FFFF}}, {OUT{32'h8000_0000}},
                     {OUT{32'hF000_0000}}, {OUT{32'h8000_0000}},
                     1'b1, 5'd0, 2'd0, 1, 1, 16, 1'b1);
        vecs[4] = mk(1'b0, 3, 0, pk(0, 7*U, 3*U, -U, 2*U, 5*U, 7*U, U), '0,
                     {OUT{32'hF000_0000}}, {OUT{32'h8000_0000}},
                     1'b1, 5'd1, 2'd0, 1, 0, 12, 1'b1);
        vecs[5] = mk(1'b1, 0, 2, pk(0, 7*U, 3*U, -U, 2*U, 5*U, 7*U, U), '0,
                     {OUT{32'hF000_0000}}, {OUT{32'h8000_0000}},
                     1'b0, 5'd0, 2'd1, 1, 0, 257, 1'b1);
        vecs[6] = mk(1'b1, 3, 0, pk(0, 7*U, 3*U, -U, 2*U, 5*U, 7*U, U),
                     pk(0, 7*U, 3*U, -U, 2*U, 5*U, 7*U, U), '0, '0,
                     1'b1, 5'd1, 2'd2, 1, 1, 270, 1'b1);
        vecs[7] = mk(1'b0, 3, 0, pk(-U, U, 0, 3*U, -8*U, 2*U, 0, 0), '0,
                     '0, '0, 1'b1, 5'd3, 2'd0, 1, 0, 12, 1'b1);

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_train = 1'b0;
        s_x_pk  = '0;
        s_t_pk  = '0;
        a3_pk   = '0;
        r_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_s_ready", 512'(s_ready), 512'(1));
        checkOutput("reset_fp_bp", 512'({fp, bp}), 512'(0));
        checkOutput("reset_r_valid", 512'(r_valid), 512'(0));
        checkOutput("reset_r_class", 512'(r_class), 512'(0));
        checkOutput("reset_r_status", 512'(r_status), 512'(0));
        checkOutput("reset_a0", 512'(a0_pk), 512'(0));
        checkOutput("reset_g3", 512'(g3_pk), 512'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], i, 1'b1);
        end

        // Stray done pulse while idle must not start or advance anything.
        @(posedge clk); #1;
        stray_fp = 1'b1;
        @(posedge clk); #1;
        stray_fp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("stray_s_ready_c%0d", i), 512'(s_ready), 512'(1));
            checkOutput($sformatf("stray_fp_c%0d", i), 512'({fp, r_valid}), 512'(0));
            @(posedge clk); #1;
        end

        applyStimulus(vecs[7], 8, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("hold_r_valid_c%0d", i), 512'(r_valid), 512'(1));
            checkOutput($sformatf("hold_r_class_c%0d", i), 512'(r_class), 512'(3));
            checkOutput($sformatf("hold_s_ready_c%0d", i), 512'(s_ready), 512'(0));
        end
        r_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("release_r_valid", 512'(r_valid), 512'(0));
        checkOutput("release_s_ready", 512'(s_ready), 512'(1));

        startSample(vecs[6], 9);
        begin
            int cyc;
            cyc = 0;
            while (!bp && cyc < 40) begin
                @(posedge clk); #1;
                cyc++;
            end
            checkOutput("midreset_bp_seen", 512'(bp), 512'(1));
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("midreset_s_ready", 512'(s_ready), 512'(1));
        checkOutput("midreset_r_valid", 512'(r_valid), 512'(0));
        checkOutput("midreset_bp", 512'(bp), 512'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("midreset_idle_after", 512'({s_ready, fp, r_valid}), 512'(3'b100));
        applyStimulus(vecs[1], 10, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
